fetch_decode_stage: RTL and testbench

//   Fetch/decode front end of the ARM-subset core; sits directly upstream of RegisterFile.
//   - Holds the program counter; issues fetch addresses; latches returned instructions into a decode register.
//   - Drives the RegisterFile read/write addresses (A1, A2, A3) and the R15 value (PC+8).
//   - Handles stall, flush and branch redirect.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/instr_field_decoder.sv | 48 ++++
 rtl/fetch_decode_stage.sv | 75 +++++++
 tb/tb_fetch_decode_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM-subset core front end.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10
  } op_t;

  localparam logic [3:0]  REG_PC    = 4'd15;
  localparam logic [3:0]  REG_LR    = 4'd14;
  localparam logic [31:0] PC_OFFSET = 32'd8;

  // Register-file addressing derived from one instruction word.
  typedef struct packed {
    logic [3:0] a1;
    logic [3:0] a2;
    logic [3:0] a3;
    logic [1:0] op;
    logic       link;
  } dec_t;

endpackage

// File: rtl/instr_field_decoder.sv
// Combinational field extraction: instruction word -> register addresses, op class, link flag.
// BRANCH_LINK_EN routes BL destinations to the link register.
module instr_field_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [3:0] rn, rd, rm;
  logic       unused_bits;

  assign rn = instr[19:16];
  assign rd = instr[15:12];
  assign rm = instr[3:0];
  assign unused_bits = ^instr;

  always_comb begin
    dec    = '0;
    dec.op = instr[27:26];
    case (instr[27:26])
      OP_DP: begin
        dec.a1 = rn;
        dec.a2 = rm;
        dec.a3 = rd;
      end
      OP_MEM: begin
        // stores read Rd as data, loads write it; both addressed the same way
        dec.a1 = rn;
        dec.a2 = rd;
        dec.a3 = rd;
      end
      OP_BR: begin
        dec.a1 = REG_PC;
        dec.a2 = rm;
        dec.a3 = rd;
`ifdef BRANCH_LINK_EN
        if (instr[24]) begin
          dec.a3   = REG_LR;
          dec.link = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: PC, decode register, and RegisterFile address/R15 drive.
// Optional BL link-register steering via BRANCH_LINK_EN (see instr_field_decoder).
module fetch_decode_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [3:0]  A1,
  output logic [3:0]  A2,
  output logic [3:0]  A3,
  output logic [31:0] R15,
  output logic [31:0] instr_d,
  output logic        valid_d,
  output logic [1:0]  op_d,
  output logic        link_d
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0] pc, pc_d;
  logic        fetch_adv;
  dec_t        dec;

  // fetch is consumed whenever the word is valid and the stage isn't frozen
  assign fetch_adv = imem_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      pc_d    <= RESET_PC;
      instr_d <= '0;
      valid_d <= 1'b0;
    end else if (branch_taken) begin
      pc      <= branch_target;
      valid_d <= 1'b0;
    end else if (flush) begin
      valid_d <= 1'b0;
      if (fetch_adv) pc <= pc + STEP;
    end else if (!stall) begin
      if (imem_valid) begin
        instr_d <= imem_rdata;
        pc_d    <= pc;
        valid_d <= 1'b1;
        pc      <= pc + STEP;
      end else begin
        valid_d <= 1'b0;
      end
    end
  end

  assign imem_addr = pc;
  assign R15       = pc_d + PC_OFFSET;

  instr_field_decoder u_dec (
    .instr (instr_d),
    .dec   (dec)
  );

  assign A1     = dec.a1;
  assign A2     = dec.a2;
  assign A3     = dec.a3;
  assign op_d   = dec.op;
  assign link_d = dec.link;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed + randomized check of fetch_decode_stage against a behavioural model.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [3:0]  A1, A2, A3;
  logic [31:0] R15, instr_d;
  logic        valid_d, link_d;
  logic [1:0]  op_d;

  int checks = 0;
  int errors = 0;

  // reference state; m_known clears when instr_d/pc_d become unspecified
  logic [31:0] m_pc, m_pc_d, m_instr;
  logic        m_valid, m_known;

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .A1(A1), .A2(A2), .A3(A3), .R15(R15), .instr_d(instr_d),
    .valid_d(valid_d), .op_d(op_d), .link_d(link_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // expected {A1,A2,A3,link} from the instruction-class table
  task automatic ref_decode(input logic [31:0] w, output int a1, output int a2,
                            output int a3, output int lk);
    int op, rn, rd, rm;
    op = int'((w >> 26) % 4);
    rn = int'((w >> 16) % 16);
    rd = int'((w >> 12) % 16);
    rm = int'(w % 16);
    a1 = 0; a2 = 0; a3 = 0; lk = 0;
    if (op == 0)      begin a1 = rn; a2 = rm; a3 = rd; end
    else if (op == 1) begin a1 = rn; a2 = rd; a3 = rd; end
    else if (op == 2) begin
      a1 = 15; a2 = rm; a3 = rd;
`ifdef BRANCH_LINK_EN
      if (((w >> 24) % 2) == 1) begin a3 = 14; lk = 1; end
`endif
    end
  endtask

  task automatic check_all();
    int a1, a2, a3, lk;
    chk("imem_addr", imem_addr, m_pc);
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
    if (m_known) begin
      ref_decode(m_instr, a1, a2, a3, lk);
      chk("instr_d", instr_d, m_instr);
      chk("R15", R15, m_pc_d + 32'd8);
      chk("A1", {28'b0, A1}, 32'(a1));
      chk("A2", {28'b0, A2}, 32'(a2));
      chk("A3", {28'b0, A3}, 32'(a3));
      chk("op_d", {30'b0, op_d}, (m_instr >> 26) % 4);
      chk("link_d", {31'b0, link_d}, 32'(lk));
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [31:0] rd,
                      input logic st, input logic fl, input logic br,
                      input logic [31:0] tgt);
    rst = r; imem_valid = iv; imem_rdata = rd; stall = st; flush = fl;
    branch_taken = br; branch_target = tgt;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_pc_d = 32'h0; m_instr = '0; m_valid = 1'b0; m_known = 1'b1;
    end else if (br) begin
      m_pc = tgt; m_valid = 1'b0; m_known = 1'b0;
    end else if (fl) begin
      m_valid = 1'b0; m_known = 1'b0;
      if (iv && !st) m_pc = m_pc + 32'd4;
    end else if (st) begin
    end else if (iv) begin
      m_instr = rd; m_pc_d = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4; m_known = 1'b1;
    end else begin
      m_valid = 1'b0; m_known = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    m_pc = '0; m_pc_d = '0; m_instr = '0; m_valid = 1'b0; m_known = 1'b0;

    // reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h1234_5678, 0, 0, 0, 0);
    chk("rst_R15", R15, 32'h8);
    chk("rst_A3", {28'b0, A3}, 32'h0);

    // sequential fetch of a data-processing op
    step(0, 1, 32'hE082_1003, 0, 0, 0, 0);
    chk("t1_A1", {28'b0, A1}, 32'd2);
    chk("t1_A2", {28'b0, A2}, 32'd3);
    chk("t1_A3", {28'b0, A3}, 32'd1);
    chk("t1_R15a", R15, 32'd8);
    step(0, 1, 32'hE082_1003, 0, 0, 0, 0);
    chk("t1_R15b", R15, 32'd12);
    step(0, 1, 32'hE082_1003, 0, 0, 0, 0);
    chk("t1_addr", imem_addr, 32'hC);

    // stall ignores changing rdata
    step(0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0);
    step(0, 1, 32'h0BAD_F00D, 1, 0, 0, 0);
    chk("t2_instr", instr_d, 32'hE082_1003);

    // branch wins over stall
    step(0, 1, 32'h1111_1111, 1, 0, 1, 32'h100);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_valid", {31'b0, valid_d}, 32'd0);
    step(0, 1, 32'hE591_2004, 0, 0, 0, 0);

    // one-cycle bubble, then resume
    step(0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("t4_addr", imem_addr, 32'h104);
    step(0, 1, 32'hE3A0_0001, 0, 0, 0, 0);

    // flush: advancing and held variants
    step(0, 1, 32'h2222_2222, 0, 1, 0, 0);
    step(0, 1, 32'h3333_3333, 1, 1, 0, 0);
    step(0, 1, 32'hE082_1003, 0, 0, 0, 0);

    // PC wrap
    step(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(0, 1, 32'hE082_1003, 0, 0, 0, 0);
    chk("t5_addr", imem_addr, 32'h0);
    chk("t5_R15", R15, 32'h4);

    // BL decode
    step(0, 1, 32'hEB00_0004, 0, 0, 0, 0);
    chk("t6_A1", {28'b0, A1}, 32'd15);
`ifdef BRANCH_LINK_EN
    chk("t6_A3", {28'b0, A3}, 32'd14);
    chk("t6_link", {31'b0, link_d}, 32'd1);
`else
    chk("t6_A3", {28'b0, A3}, 32'd0);
    chk("t6_link", {31'b0, link_d}, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom(),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
